axil_master_fsm: RTL and testbench
==================================

AXIL_MASTER_FSM -- requirements
Module: axil_master_fsm

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, address width of command and AXI-Lite address channels.
REQ-002 SHALL have parameter DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have port m_axil_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port m_axil_resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1  command handshake.
REQ-006 SHALL have ports cmd_we input 1 (1=write), cmd_addr input ADDR_WIDTH, cmd_wdata input DATA_WIDTH, cmd_wstrb input DATA_WIDTH/8  command payload.
REQ-007 SHALL have ports rsp_valid output 1, rsp_ready input 1  response handshake.
REQ-008 SHALL have ports rsp_we output 1, rsp_rdata output DATA_WIDTH, rsp_resp output 2  response payload.
REQ-009 SHALL have AXI-Lite master ports m_axil_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready, with standard directions and widths.
REQ-010 SHALL have ports wr_count output 16, rd_count output 16, err_flag output 1  status.

Function
REQ-011 SHALL allow one outstanding transaction; states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-012 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
REQ-013 On an accepted write, the cycle after acceptance SHALL assert awvalid and wvalid together, with awaddr/wdata/wstrb registered from the command; next state WR_REQ.
REQ-014 In WR_REQ, awvalid SHALL drop the cycle after its handshake and wvalid the cycle after its handshake, independently; either order or simultaneous handshake SHALL be accepted.
REQ-015 Valid signals SHALL never drop before their handshake, and payloads SHALL stay stable while valid is high.
REQ-016 When both AW and W have completed, the FSM SHALL enter WR_RESP with bready=1; bready SHALL be 0 in all other states.
REQ-017 On bvalid&&bready, the FSM SHALL capture bresp into rsp_resp, set rsp_we=1, clear rsp_rdata, and enter RSP.
REQ-018 On an accepted read, the cycle after acceptance SHALL assert arvalid with the registered address; next state RD_REQ.
REQ-019 In RD_REQ, arvalid SHALL drop the cycle after its handshake; the FSM SHALL then enter RD_DATA with rready=1.
REQ-020 On rvalid&&rready, the FSM SHALL capture rdata and rresp, set rsp_we=0, and enter RSP.
REQ-021 In RSP, rsp_valid SHALL be 1 and the payload stable until rsp_ready; on rsp_valid&&rsp_ready the FSM SHALL return to IDLE; a new command SHALL be acceptable in the following cycle.
REQ-022 Minimum latency SHALL be 3 cycles from command acceptance to rsp_valid when slave ready/valid are constantly high.
REQ-023 wr_count/rd_count SHALL increment by 1 on each B/R handshake and wrap from 0xFFFF to 0.
REQ-024 err_flag SHALL set sticky when a captured bresp/rresp is not 2'b00 and clear only on reset.
REQ-025 bvalid while not in WR_RESP and rvalid while not in RD_DATA SHALL be ignored.

Reset
REQ-026 While m_axil_resetn=0 at a clock edge, all valid/ready outputs SHALL be 0 except cmd_ready, and all payloads, counters and err_flag SHALL be 0; the state SHALL be IDLE.
REQ-027 cmd_ready SHALL be 0 during reset and 1 in the first cycle after release.
REQ-028 Reset during any state SHALL abandon the transaction without a response.

Structure
REQ-029 The state enum and the response codes OKAY=2'b00 and SLVERR=2'b10 SHALL live in the shared package axil_pkg.
REQ-030 The block SHALL be a single module with no sub-modules.

Verification
REQ-031 Write 0x0000_0010/0xDEAD_BEEF/strb 0xF with slave always ready and bresp=00 -> AW and W in cycle 1, rsp_valid in cycle 3, rsp_resp=00, wr_count=1.
REQ-032 Write with wready delayed 4 cycles after awready -> awvalid drops after its handshake, wvalid held 4 cycles, one B accepted.
REQ-033 Read 0x0000_0020 with rdata=0x1234_5678 and rvalid delayed 2 cycles -> rsp_rdata=0x1234_5678, rsp_we=0, rd_count=1.
REQ-034 Read with rresp=2'b10 -> rsp_resp=10, err_flag=1 and still 1 after a following OKAY read.
REQ-035 rsp_ready held low 5 cycles -> rsp payload stable, cmd_ready=0 throughout; back-to-back command accepted the cycle after the response handshake.
REQ-036 Reset asserted in WR_REQ -> all outputs at reset values next cycle, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite master sequencer.
//   state_t      : controller states
//   OKAY/SLVERR  : AXI response codes used when classifying B/R responses
//   resp_is_err  : 1 when a response code is anything other than OKAY
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/axil_master_fsm.sv
// Single-outstanding AXI-Lite master. A command (read or write) is accepted
// in IDLE, issued on the AXI-Lite channels, and its completion is returned
// on the response port.
// Ports:
//   m_axil_clk, m_axil_resetn : clock, synchronous active-low reset
//   cmd_*                     : command valid/ready handshake plus payload
//   rsp_*                     : response valid/ready handshake plus payload
//   m_axil_aw*/w*/b*/ar*/r*   : AXI-Lite master channels
//   wr_count, rd_count        : completed B / R handshakes (wrapping)
//   err_flag                  : sticky, set by any non-OKAY response
//
// state   | meaning
// IDLE    | waiting for a command; cmd_ready high
// WR_REQ  | AW and W outstanding, each dropped after its own handshake
// WR_RESP | both AW and W done; bready high, waiting for B
// RD_REQ  | AR outstanding
// RD_DATA | AR done; rready high, waiting for R
// RSP     | rsp_valid high, payload held until rsp_ready
module axil_master_fsm
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    m_axil_clk,
  input  logic                    m_axil_resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_we,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready,
  output logic [15:0]             wr_count,
  output logic [15:0]             rd_count,
  output logic                    err_flag
);

  state_t state_q, state_d;

  logic cmd_acc, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  // Handshakes are qualified by state, not by the comb ready outputs, so
  // the next-state logic below has no path back into itself.
  assign cmd_acc = cmd_valid && (state_q == IDLE);
  assign aw_hs   = m_axil_awvalid && m_axil_awready;
  assign w_hs    = m_axil_wvalid && m_axil_wready;
  assign ar_hs   = m_axil_arvalid && m_axil_arready;
  assign b_hs    = m_axil_bvalid && (state_q == WR_RESP);
  assign r_hs    = m_axil_rvalid && (state_q == RD_DATA);
  assign rsp_hs  = rsp_ready && (state_q == RSP);

  always_ff @(posedge m_axil_clk) begin
    if (!m_axil_resetn) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    // gated by reset so cmd_ready stays low while reset is held
    cmd_ready     = m_axil_resetn && (state_q == IDLE);
    m_axil_bready = (state_q == WR_RESP);
    m_axil_rready = (state_q == RD_DATA);
    rsp_valid     = (state_q == RSP);
    case (state_q)
      IDLE:    if (cmd_acc) state_d = cmd_we ? WR_REQ : RD_REQ;
      // a channel is finished once its valid is low or handshaking now
      WR_REQ:  if ((!m_axil_awvalid || aw_hs) && (!m_axil_wvalid || w_hs))
                 state_d = WR_RESP;
      WR_RESP: if (b_hs)   state_d = RSP;
      RD_REQ:  if (ar_hs)  state_d = RD_DATA;
      RD_DATA: if (r_hs)   state_d = RSP;
      RSP:     if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axil_clk) begin
    if (!m_axil_resetn) begin
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      rsp_we         <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= OKAY;
      wr_count       <= '0;
      rd_count       <= '0;
      err_flag       <= 1'b0;
    end else begin
      if (cmd_acc) begin
        if (cmd_we) begin
          m_axil_awaddr  <= cmd_addr;
          m_axil_wdata   <= cmd_wdata;
          m_axil_wstrb   <= cmd_wstrb;
          m_axil_awvalid <= 1'b1;
          m_axil_wvalid  <= 1'b1;
        end else begin
          m_axil_araddr  <= cmd_addr;
          m_axil_arvalid <= 1'b1;
        end
      end
      if (aw_hs) m_axil_awvalid <= 1'b0;
      if (w_hs)  m_axil_wvalid  <= 1'b0;
      if (ar_hs) m_axil_arvalid <= 1'b0;
      if (b_hs) begin
        rsp_we    <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= m_axil_bresp;
        wr_count  <= wr_count + 16'd1;
        if (resp_is_err(m_axil_bresp)) err_flag <= 1'b1;
      end
      if (r_hs) begin
        rsp_we    <= 1'b0;
        rsp_rdata <= m_axil_rdata;
        rsp_resp  <= m_axil_rresp;
        rd_count  <= rd_count + 16'd1;
        if (resp_is_err(m_axil_rresp)) err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axil_master_fsm.sv
// Bench for axil_master_fsm. A slave is emulated with per-transaction ready
// and response delays; the expected cycle-by-cycle behaviour is derived from
// those delays with plain arithmetic, and counters/error flag are tracked
// in a small transaction-level model.
module tb_axil_master_fsm;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic [15:0]   wr_count, rd_count;
  logic          err_flag;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_wr, m_rd;
  logic        m_err;

  always #5 clk = ~clk;

  axil_master_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .m_axil_clk(clk), .m_axil_resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
    .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready),
    .wr_count(wr_count), .rd_count(rd_count), .err_flag(err_flag)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_araddr", araddr, 0);
    check("rst_rsp_we", rsp_we, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_err_flag", err_flag, 0);
  endtask

  // Idle cycles with stray B/R valids carrying an error code: all ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      bvalid = 1'b1; bresp = 2'b10; rvalid = 1'b1; rresp = 2'b10;
      rdata = $urandom;
      check("idle_cmd_ready", cmd_ready, 1);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_bready", bready, 0);
      check("idle_rready", rready, 0);
      check("idle_wr_count", wr_count, m_wr);
      check("idle_rd_count", rd_count, m_rd);
      check("idle_err_flag", err_flag, m_err);
    end
  endtask

  // d_a: AW (write) or AR (read) ready delay; d_w: W ready delay;
  // d_resp: B/R valid delay; d_rsp: cycles rsp_ready is held low.
  task automatic run_txn(input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb,
                         input logic [1:0] resp, input int d_a, input int d_w,
                         input int d_resp, input int d_rsp);
    int ph2, hs_cyc, rsp_cyc, end_cyc;
    logic [15:0] exp_wr, exp_rd;
    logic exp_err, in_wait;
    if (we) ph2 = 2 + ((d_a > d_w) ? d_a : d_w);
    else    ph2 = 2 + d_a;
    hs_cyc  = ph2 + d_resp;
    rsp_cyc = hs_cyc + 1;
    end_cyc = rsp_cyc + d_rsp;
    exp_wr  = we ? m_wr + 16'd1 : m_wr;
    exp_rd  = we ? m_rd : m_rd + 16'd1;
    exp_err = m_err || (resp != 2'b00);

    @(negedge clk);
    clear_slave();
    rsp_ready = 1'b0;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;

    for (int cyc = 1; cyc <= end_cyc; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_we = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
      in_wait = (cyc >= ph2) && (cyc <= hs_cyc);
      awready = we && (cyc >= 1 + d_a);
      wready  = we && (cyc >= 1 + d_w);
      arready = !we && (cyc >= 1 + d_a);
      if (we) begin
        bvalid = in_wait ? (cyc == hs_cyc) : 1'($urandom);
        bresp  = (cyc == hs_cyc) ? resp : 2'($urandom);
        rvalid = 1'($urandom); rresp = 2'($urandom); rdata = $urandom;
      end else begin
        rvalid = in_wait ? (cyc == hs_cyc) : 1'($urandom);
        rresp  = (cyc == hs_cyc) ? resp : 2'($urandom);
        rdata  = (cyc == hs_cyc) ? data : $urandom;
        bvalid = 1'($urandom); bresp = 2'($urandom);
      end
      if (cyc < rsp_cyc) rsp_ready = 1'($urandom);
      else               rsp_ready = (cyc == end_cyc);

      check("cmd_ready_busy", cmd_ready, 0);
      check("awvalid", awvalid, we && (cyc <= 1 + d_a));
      check("wvalid", wvalid, we && (cyc <= 1 + d_w));
      check("arvalid", arvalid, !we && (cyc <= 1 + d_a));
      check("bready", bready, we && in_wait);
      check("rready", rready, !we && in_wait);
      check("rsp_valid", rsp_valid, cyc >= rsp_cyc);
      if (we && cyc <= 1 + d_a) check("awaddr", awaddr, addr);
      if (we && cyc <= 1 + d_w) begin
        check("wdata", wdata, data);
        check("wstrb", wstrb, strb);
      end
      if (!we && cyc <= 1 + d_a) check("araddr", araddr, addr);
      if (cyc >= rsp_cyc) begin
        check("rsp_we", rsp_we, we);
        check("rsp_resp", rsp_resp, resp);
        check("rsp_rdata", rsp_rdata, we ? '0 : data);
        check("wr_count", wr_count, exp_wr);
        check("rd_count", rd_count, exp_rd);
        check("err_flag", err_flag, exp_err);
      end
    end
    m_wr = exp_wr; m_rd = exp_rd; m_err = exp_err;
  endtask

  initial begin
    bit       r_we;
    int       gap;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    clear_slave();
    m_wr = '0; m_rd = '0; m_err = 1'b0;
    resetn = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_outputs();
    resetn = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_release", cmd_ready, 1);

    // directed write, zero-wait slave: rsp_valid 3 cycles after acceptance
    run_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0, 0, 0);
    check("wr_count_first", wr_count, 1);
    // W ready 4 cycles after AW
    run_txn(1, 32'h0000_0044, 32'hCAFE_F00D, 4'h5, 2'b00, 0, 4, 0, 0);
    // AW late relative to W
    run_txn(1, 32'h0000_0048, 32'h0BAD_CAFE, 4'h3, 2'b00, 3, 0, 1, 0);
    // read, R valid delayed 2 cycles
    run_txn(0, 32'h0000_0020, 32'h1234_5678, 4'h0, 2'b00, 0, 0, 2, 0);
    check("rd_count_first", rd_count, 1);
    // SLVERR read, then OKAY read: error flag stays set
    run_txn(0, 32'h0000_0024, 32'h5555_AAAA, 4'h0, 2'b10, 1, 0, 1, 0);
    check("err_after_slverr", err_flag, 1);
    run_txn(0, 32'h0000_0028, 32'h0F0F_0F0F, 4'h0, 2'b00, 0, 0, 0, 0);
    check("err_sticky", err_flag, 1);
    // response stalled 5 cycles, then back-to-back command
    run_txn(1, 32'h0000_0030, 32'hA5A5_5A5A, 4'hC, 2'b00, 0, 0, 0, 5);
    run_txn(0, 32'h0000_0034, 32'h7777_1111, 4'h0, 2'b00, 0, 0, 0, 0);
    idle_cycles(3);

    for (int i = 0; i < 40; i++) begin
      r_we = 1'($urandom);
      run_txn(r_we, $urandom, $urandom, 4'($urandom), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      gap = int'($urandom_range(0, 2));
      idle_cycles(gap);
    end

    // reset while in WR_REQ abandons the write
    @(negedge clk);
    clear_slave();
    check("pre_rst_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0100;
    cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wrreq_awvalid", awvalid, 1);
    @(negedge clk);
    check("wrreq_wvalid_held", wvalid, 1);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    resetn = 1'b1;
    m_wr = '0; m_rd = '0; m_err = 1'b0;
    bvalid = 1'b1; bresp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_cmd_ready", cmd_ready, 1);
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("post_rst_awvalid", awvalid, 0);
      check("post_rst_wr_count", wr_count, 0);
    end
    run_txn(1, 32'h0000_0200, 32'h3333_4444, 4'hF, 2'b00, 1, 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
